// File: rtl/fm_row_pingpong_buffer_if.sv
// fm_row_pingpong_buffer_if: source-FIFO, PE-read and bank-switch signals of the ping-pong row buffer
interface fm_row_pingpong_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 3,
  parameter int LANE_PIX = 7,
  parameter int REAL_W = 25,
  parameter int ROW_WIDTH = 10
);
  localparam int ROW_PIX = (REAL_W + LANE_PIX - 1) / LANE_PIX * LANE_PIX;
  logic src_valid;
  logic [LANES-1:0][LANE_PIX-1:0][DATA_WIDTH-1:0] src_data;
  logic [LANES-1:0] src_rden;
  logic rd_en;
  logic [ROW_WIDTH-1:0] rd_row;
  logic [ROW_WIDTH-1:0] rd_ch;
  logic [ROW_PIX-1:0][DATA_WIDTH-1:0] rd_data;
  logic rd_data_valid;
  logic buf_valid;
  logic buf_switch;
  logic switch_err;
  modport master (
    output src_valid, src_data, rd_en, rd_row, rd_ch, buf_switch,
    input src_rden, rd_data, rd_data_valid, buf_valid, switch_err
  );
  modport slave (
    input src_valid, src_data, rd_en, rd_row, rd_ch, buf_switch,
    output src_rden, rd_data, rd_data_valid, buf_valid, switch_err
  );
endinterface

// File: rtl/fm_row_pingpong_buffer.sv
// fm_row_pingpong_buffer: double-banked feature-map row buffer with zero padding, back-pressure and sticky switch error
module fm_row_pingpong_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 3,
  parameter int LANE_PIX = 7,
  parameter int CHANNELS = 32,
  parameter int ROWS = 3,
  parameter int REAL_W = 25,
  parameter int ROW_WIDTH = 10
) (
  input logic clk,
  input logic rstn,
  fm_row_pingpong_buffer_if.slave bus
);
  localparam int ROW_WORDS = (REAL_W + LANE_PIX - 1) / LANE_PIX;
  localparam int ROW_PIX = ROW_WORDS * LANE_PIX;
  localparam int GROUPS = (CHANNELS + LANES - 1) / LANES;
  localparam int WB = ROW_WORDS > 1 ? $clog2(ROW_WORDS) : 1;
  localparam int GB = GROUPS > 1 ? $clog2(GROUPS) : 1;
  localparam int RB = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int LB = LANES > 1 ? $clog2(LANES) : 1;
  localparam int PW = ROW_PIX * DATA_WIDTH;
  localparam logic [PW-1:0] PIX_MASK = {PW{1'b1}} >> ((ROW_PIX - REAL_W) * DATA_WIDTH);
  typedef logic [ROW_PIX-1:0][DATA_WIDTH-1:0] row_t;
  logic [WB-1:0] w;
  logic [GB-1:0] g;
  logic [RB-1:0] r;
  logic wr_bank, rd_bank;
  logic [1:0] bank_full;
  logic accept, last_beat, do_switch, rd_ok, in_range;
  logic [GB-1:0] rd_grp;
  logic [LB-1:0] rd_lane;
  row_t lane_rd [LANES];
  always_comb begin
    accept = rstn && bus.src_valid && !bank_full[wr_bank];
    last_beat = accept && w == WB'(ROW_WORDS - 1) && g == GB'(GROUPS - 1) && r == RB'(ROWS - 1);
    do_switch = bus.buf_switch && bank_full[rd_bank];
    rd_ok = bus.rd_en && bank_full[rd_bank];
    in_range = bus.rd_row < ROW_WIDTH'(ROWS) && bus.rd_ch < ROW_WIDTH'(CHANNELS);
    rd_grp = GB'(bus.rd_ch / ROW_WIDTH'(LANES));
    rd_lane = LB'(bus.rd_ch % ROW_WIDTH'(LANES));
  end
  assign bus.src_rden = {LANES{accept}};
  assign bus.buf_valid = bank_full[rd_bank];
  for (genvar n = 0; n < LANES; n++) begin : g_lane
    row_t mem [2][ROWS][GROUPS];
    always_ff @(posedge clk)
      if (accept && int'(g) * LANES + n < CHANNELS)
        mem[wr_bank][r][g][int'(w) * LANE_PIX +: LANE_PIX] <= bus.src_data[n];
    assign lane_rd[n] = mem[rd_bank][bus.rd_row[RB-1:0]][rd_grp];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      w <= '0;
      g <= '0;
      r <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      bank_full <= '0;
      bus.switch_err <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_data_valid <= 1'b0;
    end else begin
      if (accept) begin
        w <= w == WB'(ROW_WORDS - 1) ? '0 : w + 1'b1;
        if (w == WB'(ROW_WORDS - 1)) begin
          g <= g == GB'(GROUPS - 1) ? '0 : g + 1'b1;
          if (g == GB'(GROUPS - 1)) r <= r == RB'(ROWS - 1) ? '0 : r + 1'b1;
        end
      end
      if (last_beat) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
      end
      if (do_switch) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
      if (bus.buf_switch && !bank_full[rd_bank]) bus.switch_err <= 1'b1;
      bus.rd_data_valid <= rd_ok;
      if (rd_ok) bus.rd_data <= in_range ? lane_rd[rd_lane] & PIX_MASK : '0;
    end
endmodule
